// File: rtl/cache_mem_responder.sv
// cache_mem_responder
//
// Backing memory at the far end of the cache controller's miss/write-back
// interface. After every reset it fills its byte array with the pattern
// (index XOR 'hA5). It then accepts one read or write at a time, services it
// LATENCY cycles after acceptance, and holds the result until the controller
// takes it.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset (restarts the fill sequence)
//   req_valid  - request present
//   req_ready  - responder can accept a request (IDLE only)
//   req_we     - 1 = write, 0 = read
//   req_addr   - entry address
//   req_wdata  - write data (ignored for reads)
//   rsp_valid  - response present
//   rsp_ready  - controller accepts the response
//   rsp_data   - read data, or echoed write data
//   rsp_write  - response belongs to a write
//   busy       - high in every state except IDLE

module cache_mem_responder #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_write,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int AD_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    // Wide enough to hold the index, the data word and the 8-bit constant,
    // so the XOR never truncates before the low DATA_W bits are taken.
    localparam int PAT_W = (AD_W > 8) ? AD_W : 8;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] idx;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PAT_W-1:0]  pat_full;
    logic [DATA_W-1:0] init_pattern;
    logic              accept;
    logic              commit;
    logic              rsp_fire;
    logic              init_last;

    assign pat_full     = PAT_W'(idx) ^ PAT_W'(8'hA5);
    assign init_pattern = pat_full[DATA_W-1:0];
    assign init_last    = (idx == {ADDR_W{1'b1}});
    assign accept       = (state == IDLE) && req_valid;
    assign commit       = (state == WAIT) && (cnt == 4'd0);
    assign rsp_fire     = (state == RESP) && rsp_ready;

    always_comb begin
        next_state = state;
        case (state)
            INIT:    if (init_last) next_state = IDLE;
            IDLE:    if (accept)    next_state = WAIT;
            WAIT:    if (commit)    next_state = RESP;
            RESP:    if (rsp_fire)  next_state = IDLE;
            default:                next_state = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Handshake outputs are registered from next_state so they are clean
    // flop outputs that line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_data  <= '0;
            rsp_write <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            req_ready <= (next_state == IDLE);
            rsp_valid <= (next_state == RESP);
            busy      <= (next_state != IDLE);
            case (state)
                INIT: begin
                    idx <= idx + ADDR_W'(1);
                end
                IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= 4'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (commit) begin
                        rsp_data  <= lat_we ? lat_wdata : mem[lat_addr];
                        rsp_write <= lat_we;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Single write port shared by the fill sequence and committed writes;
    // the two can never coincide because they live in different states.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[idx] <= init_pattern;
            end else if (commit && lat_we) begin
                mem[lat_addr] <= lat_wdata;
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder
//
// Self-checking bench for cache_mem_responder with default parameters.
// A byte-array reference memory holds the expected contents (fill pattern
// plus committed writes); directed scenarios are followed by random traffic.

module tb_cache_mem_responder;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 2 ** ADDR_W;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_write;
    logic              busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int accept_cyc;
    int hs_cyc;

    logic [DATA_W-1:0] model_mem [DEPTH];

    cache_mem_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LATENCY(LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_write(rsp_write),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference contents right after a fill: entry i holds i XOR 'hA5.
    task automatic modelInit();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = 8'(i ^ 'hA5);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
    endtask

    // Releases reset and expects exactly DEPTH busy cycles before IDLE.
    task automatic waitInit(input string tag);
        int count;
        int viol;
        count = 0;
        viol  = 0;
        rst   = 1'b0;
        while (!req_ready && count < 300) begin
            tick();
            count++;
            if (rsp_valid) viol++;
            if (!req_ready && !busy) viol++;
        end
        checkOutput({tag, "_init_cycles"}, count, DEPTH);
        checkOutput({tag, "_init_idle_busy"}, {31'd0, busy}, 0);
        checkOutput({tag, "_init_violations"}, viol, 0);
    endtask

    // One full transaction. hold = cycles the response is back-pressured;
    // keep_valid leaves req_valid high after acceptance.
    task automatic doTxn(input string tag, input logic we,
                         input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata,
                         input int hold, input bit keep_valid);
        int k;
        logic [DATA_W-1:0] expected;
        applyStimulus(we, addr, wdata);
        rsp_ready = (hold == 0);
        k = 0;
        while (!req_ready && k < 50) begin
            tick();
            k++;
        end
        checkOutput({tag, "_ready_before"}, {31'd0, req_ready}, 1);
        tick();
        accept_cyc = cyc;
        checkOutput({tag, "_ready_after_accept"}, {31'd0, req_ready}, 0);
        checkOutput({tag, "_busy_after_accept"}, {31'd0, busy}, 1);
        if (!keep_valid) req_valid = 1'b0;
        if (we) begin
            expected = wdata;
            model_mem[addr] = wdata;
        end else begin
            expected = model_mem[addr];
        end
        k = 0;
        while (!rsp_valid && k < 50) begin
            tick();
            k++;
        end
        checkOutput({tag, "_latency"}, k, LATENCY);
        checkOutput({tag, "_data"}, {24'd0, rsp_data}, {24'd0, expected});
        checkOutput({tag, "_write"}, {31'd0, rsp_write}, {31'd0, we});
        for (int h = 0; h < hold; h++) begin
            tick();
            checkOutput({tag, "_hold_valid"}, {31'd0, rsp_valid}, 1);
            checkOutput({tag, "_hold_data"}, {24'd0, rsp_data}, {24'd0, expected});
            checkOutput({tag, "_hold_ready"}, {31'd0, req_ready}, 0);
        end
        rsp_ready = 1'b1;
        tick();
        hs_cyc = cyc;
        checkOutput({tag, "_valid_after_hs"}, {31'd0, rsp_valid}, 0);
        checkOutput({tag, "_ready_after_hs"}, {31'd0, req_ready}, 1);
    endtask

    initial begin
        int prev_accept;
        int prev_hs;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // Reset values
        tick();
        tick();
        tick();
        checkOutput("rst_req_ready", {31'd0, req_ready}, 0);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        checkOutput("rst_rsp_data", {24'd0, rsp_data}, 0);
        checkOutput("rst_rsp_write", {31'd0, rsp_write}, 0);
        checkOutput("rst_busy", {31'd0, busy}, 1);

        modelInit();
        waitInit("boot");

        // Unwritten read: 0x08 -> 0xAD
        doTxn("rd08", 1'b0, 7'h08, 8'h00, 0, 1'b0);
        checkOutput("rd08_pattern", {24'd0, rsp_data}, 32'hAD);

        // Write then read
        doTxn("wr04", 1'b1, 7'h04, 8'h3C, 0, 1'b0);
        doTxn("rd04", 1'b0, 7'h04, 8'h00, 0, 1'b0);
        checkOutput("rd04_value", {24'd0, rsp_data}, 32'h3C);
        doTxn("rd05", 1'b0, 7'h05, 8'h00, 0, 1'b0);
        checkOutput("rd05_pattern", {24'd0, rsp_data}, 32'hA0);

        // Backpressure with req_valid held: next acceptance one cycle after handshake
        doTxn("bp7f", 1'b0, 7'h7F, 8'h00, 5, 1'b1);
        checkOutput("bp7f_pattern", {24'd0, rsp_data}, 32'hDA);
        prev_hs = hs_cyc;
        doTxn("bp7f_next", 1'b0, 7'h7F, 8'h00, 0, 1'b0);
        checkOutput("bp_next_accept_gap", accept_cyc - prev_hs, 1);

        // Reset in the middle of WAIT discards the write
        applyStimulus(1'b1, 7'h10, 8'h77);
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        checkOutput("rstw_accepted", {31'd0, req_ready}, 0);
        tick();
        tick();
        checkOutput("rstw_no_valid_pre", {31'd0, rsp_valid}, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rstw_no_valid", {31'd0, rsp_valid}, 0);
            checkOutput("rstw_busy", {31'd0, busy}, 1);
        end
        modelInit();
        waitInit("rstw");
        doTxn("rd10", 1'b0, 7'h10, 8'h00, 0, 1'b0);
        checkOutput("rd10_pattern", {24'd0, rsp_data}, 32'hB5);

        // Throughput: three reads back to back
        doTxn("tp0", 1'b0, 7'h21, 8'h00, 0, 1'b1);
        prev_accept = accept_cyc;
        doTxn("tp1", 1'b0, 7'h42, 8'h00, 0, 1'b1);
        checkOutput("tp_gap1", accept_cyc - prev_accept, LATENCY + 2);
        prev_accept = accept_cyc;
        doTxn("tp2", 1'b0, 7'h63, 8'h00, 0, 1'b0);
        checkOutput("tp_gap2", accept_cyc - prev_accept, LATENCY + 2);

        // Random traffic against the reference memory
        for (int n = 0; n < 40; n++) begin
            doTxn("rand", 1'($urandom_range(0, 1)), 7'($urandom_range(0, DEPTH - 1)),
                  8'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Backing-memory responder for the cache controller: the far end of the controller's miss/write-back interface. It accepts one read or write request at a time over a valid/ready channel. It services each request against an internal byte-array memory after a fixed programmable latency and returns a result over a second valid/ready channel. After every reset it self-initialises its contents to a known pattern, so reads of never-written lines are deterministic in simulation and on silicon.

## Interface
Parameters:
- ADDR_W, 7, address width; DEPTH = 2^ADDR_W entries.
- DATA_W, 8, data width per entry.
- LATENCY, 4, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request; high only in IDLE.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  entry address.
- req_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  controller accepts the response.
- rsp_data  output  DATA_W  read data, or echoed write data.
- rsp_write  output  1  response belongs to a write.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states: INIT, IDLE, WAIT, RESP.
- **INIT**
  - Index counter idx starts at 0.
  - Each cycle writes mem[idx] = low DATA_W bits of (idx XOR 'hA5), zero-extended if DATA_W > 8, then idx increments.
  - After writing idx = DEPTH-1, go to IDLE.
- **IDLE**
  - req_ready = 1.
  - On an edge with req_valid & req_ready, latch req_we/req_addr/req_wdata, load the latency counter with LATENCY-1, and go to WAIT.
- **WAIT**
  - Counter decrements each edge.
  - On the edge where the counter is 0, commit the operation and go to RESP:
    - write: mem[addr] <= wdata; rsp_data <= wdata.
    - read: rsp_data <= mem[addr].
    - In both cases rsp_write <= latched we.
- **RESP**
  - rsp_valid = 1.
  - rsp_data and rsp_write are held stable until the handshake.
  - On an edge with rsp_valid & rsp_ready, go to IDLE.
- Only one transaction is in flight. req_valid outside IDLE is ignored and does not stall the FSM.
- A write becomes memory-visible only at the commit edge. A later read of the same address returns the new value.
- Reset: forces INIT with idx = 0 from any state.
  - An uncommitted write in WAIT is discarded.
  - INIT then overwrites all memory, so committed writes are also lost.
  - While rst is held, the FSM stays in INIT at idx = 0.

## Timing
- Reset values, valid the cycle after the reset edge:
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_write = 0, busy = 1.
  - State = INIT, idx = 0.
- INIT duration is exactly DEPTH cycles after rst deasserts. req_ready first reads 1 after the DEPTH-th edge following release.
- Acceptance edge E0:
  - req_ready drops and busy rises after E0.
  - rsp_valid rises after edge E0+LATENCY.
- Response handshake at edge E1:
  - rsp_valid drops and req_ready rises after E1.
  - The earliest next acceptance is edge E1+1.
- Minimum transaction spacing, with rsp_ready held high: LATENCY+2 cycles acceptance-to-acceptance.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- rsp_data retains its last value while in IDLE/WAIT. It is only meaningful when rsp_valid = 1.

## Test plan
All scenarios use default parameters: ADDR_W=7, DATA_W=8, LATENCY=4.
- Reset/init: release rst and count edges.
  - Required: req_ready = 0 and busy = 1 for exactly 128 cycles, then req_ready = 1 and busy = 0.
  - rsp_valid stays 0 throughout.
- Unwritten read: read 0x08.
  - Required: rsp_valid rises 4 edges after acceptance, rsp_data = 0xAD, rsp_write = 0.
- Write then read: write 0x04 data 0x3C.
  - Required: response rsp_write = 1, rsp_data = 0x3C.
  - A following read of 0x04 returns 0x3C. A read of 0x05 returns 0xA0.
- Backpressure: read 0x7F (expected 0xDA) with rsp_ready low for 5 cycles and req_valid held high.
  - Required: rsp_valid and rsp_data remain stable, req_ready stays 0, and no second request is accepted until 1 cycle after the handshake.
- Reset mid-WAIT: write 0x10 data 0x77, assert rst 2 cycles after acceptance.
  - Required: rsp_valid never rises and busy = 1.
  - After re-init, a read of 0x10 returns 0xB5.
- Throughput: req_valid and rsp_ready held high for 3 reads.
  - Required: acceptances spaced exactly 6 cycles apart.
  - Responses return each entry's init pattern in request order.
